// File: rtl/reg_window_buf_if.sv
// Bundle for the lane window: serial in, parallel load, rotate, window out.
// slave = buffer side, master = producer/consumer side.
interface reg_window_buf_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic                   clr;
  logic                   in_valid;
  logic                   in_ready;
  logic [WIDTH-1:0]       in_data;
  logic [DEPTH-1:0]       ld_en;
  logic [DEPTH*WIDTH-1:0] ld_data;
  logic                   rot;
  logic [DEPTH*WIDTH-1:0] out_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [CW-1:0]          fill_cnt;

  modport slave (
    input  clr, in_valid, in_data,
    input  ld_en, ld_data, rot, out_ready,
    output in_ready, out_data,
    output out_valid, fill_cnt
  );

  modport master (
    output clr, in_valid, in_data,
    output ld_en, ld_data, rot, out_ready,
    input  in_ready, out_data,
    input  out_valid, fill_cnt
  );
endinterface

// File: rtl/reg_window_buf.sv
// DEPTH x WIDTH lane window: serial shift-in, per-lane load, rotate.
// Ports: clk, rst (sync, active-high), bus (reg_window_buf_if.slave).
module reg_window_buf #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter bit SLIDE = 1'b0
) (
  input logic             clk,
  input logic             rst,
  reg_window_buf_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [WIDTH-1:0] lane_q [DEPTH];
  logic [WIDTH-1:0] lane_d [DEPTH];
  logic [CW-1:0]    fill_q;
  logic [CW-1:0]    fill_d;

  logic out_vld;
  logic in_rdy;
  logic accept;
  logic consume;
  logic any_ld;
  logic all_ld;

  assign out_vld = (fill_q == FULL);
  assign any_ld  = |bus.ld_en;
  assign all_ld  = &bus.ld_en;
  assign consume = out_vld && bus.out_ready;

  assign in_rdy = !rst && !bus.clr && !any_ld
               && !bus.rot
               && (SLIDE || !out_vld
                   || bus.out_ready);
  assign accept = bus.in_valid && in_rdy;

  always_comb begin
    for (int i = 0; i < DEPTH; i++)
      lane_d[i] = lane_q[i];
    fill_d = fill_q;

    if (bus.clr) begin
      for (int i = 0; i < DEPTH; i++)
        lane_d[i] = '0;
      fill_d = '0;
    end else if (any_ld) begin
      for (int i = 0; i < DEPTH; i++)
        if (bus.ld_en[i])
          lane_d[i] = bus.ld_data[i*WIDTH +: WIDTH];
      if (all_ld)
        fill_d = FULL;
      else if (!SLIDE && consume)
        fill_d = '0;
    end else if (bus.rot) begin
      for (int i = 0; i < DEPTH - 1; i++)
        lane_d[i] = lane_q[i+1];
      lane_d[DEPTH-1] = lane_q[0];
      if (!SLIDE && consume)
        fill_d = '0;
    end else if (accept) begin
      for (int i = 0; i < DEPTH - 1; i++)
        lane_d[i] = lane_q[i+1];
      lane_d[DEPTH-1] = bus.in_data;
      // block mode: the accepted word opens the next window
      if (!SLIDE && consume)
        fill_d = CW'(1);
      else if (fill_q != FULL)
        fill_d = fill_q + 1'b1;
    end else if (!SLIDE && consume) begin
      fill_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++)
        lane_q[i] <= '0;
      fill_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        lane_q[i] <= lane_d[i];
      fill_q <= fill_d;
    end
  end

  always_comb begin
    bus.out_data = '0;
    for (int i = 0; i < DEPTH; i++)
      bus.out_data[i*WIDTH +: WIDTH] = lane_q[i];
  end

  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = out_vld;
  assign bus.fill_cnt  = fill_q;
endmodule

// File: tb/tb_reg_window_buf.sv
// Directed bench for reg_window_buf: block mode (b0) and sliding (b1).
// Both instances share clk/rst; 4 lanes of 32 bits.
module tb_reg_window_buf;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  reg_window_buf_if #(.WIDTH(32), .DEPTH(4)) b0 ();
  reg_window_buf_if #(.WIDTH(32), .DEPTH(4)) b1 ();

  reg_window_buf #(.WIDTH(32), .DEPTH(4), .SLIDE(1'b0)) u0 (
    .clk(clk), .rst(rst), .bus(b0.slave)
  );
  reg_window_buf #(.WIDTH(32), .DEPTH(4), .SLIDE(1'b1)) u1 (
    .clk(clk), .rst(rst), .bus(b1.slave)
  );

  function automatic logic [127:0] pk(
    input logic [31:0] a0, input logic [31:0] a1,
    input logic [31:0] a2, input logic [31:0] a3
  );
    return {a3, a2, a1, a0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    b0.clr = 0; b0.in_valid = 0; b0.in_data = '0;
    b0.ld_en = '0; b0.ld_data = '0; b0.rot = 0;
    b0.out_ready = 0;
    b1.clr = 0; b1.in_valid = 0; b1.in_data = '0;
    b1.ld_en = '0; b1.ld_data = '0; b1.rot = 0;
    b1.out_ready = 0;
  endtask

  task automatic push0(input logic [31:0] d);
    b0.in_valid = 1; b0.in_data = d;
    tick();
    b0.in_valid = 0;
  endtask

  task automatic clr0();
    b0.clr = 1;
    tick();
    b0.clr = 0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 6; i++) begin
      b0.in_valid = 1'($urandom); b0.in_data = $urandom;
      b0.out_ready = 1'($urandom);
      b1.in_valid = 1'($urandom); b1.in_data = $urandom;
      tick();
    end
    rst = 1;
    b0.in_valid = 1; b0.out_ready = 1;
    b1.in_valid = 1;
    #1;
    total++;
    if (b0.in_ready !== 1'b0 || b1.in_ready !== 1'b0)
      $display("FAIL rst_in_ready got %b/%b want 0/0",
               b0.in_ready, b1.in_ready);
    else passed++;
    tick(); tick();
    total++;
    if (b0.out_data !== '0 || b1.out_data !== '0)
      $display("FAIL rst_data got %h want 0", b0.out_data);
    else passed++;
    total++;
    if (b0.fill_cnt !== 3'd0 || b1.fill_cnt !== 3'd0)
      $display("FAIL rst_fill got %0d want 0", b0.fill_cnt);
    else passed++;
    total++;
    if (b0.out_valid !== 1'b0 || b1.out_valid !== 1'b0)
      $display("FAIL rst_valid got %b want 0", b0.out_valid);
    else passed++;
    idle();
    rst = 0;
    tick();
  endtask

  task automatic test_fill();
    push0(32'hA0); push0(32'hA1); push0(32'hA2);
    total++;
    if (b0.out_valid !== 1'b0 || b0.fill_cnt !== 3'd3)
      $display("FAIL fill3 got v=%b f=%0d want v=0 f=3",
               b0.out_valid, b0.fill_cnt);
    else passed++;
    push0(32'hA3);
    total++;
    if (b0.out_data !== pk(32'hA0, 32'hA1, 32'hA2, 32'hA3))
      $display("FAIL fill_lanes got %h", b0.out_data);
    else passed++;
    total++;
    if (b0.out_valid !== 1'b1 || b0.fill_cnt !== 3'd4)
      $display("FAIL fill4 got v=%b f=%0d want v=1 f=4",
               b0.out_valid, b0.fill_cnt);
    else passed++;
    b0.in_valid = 1; b0.in_data = 32'hEE; b0.out_ready = 0;
    #1;
    total++;
    if (b0.in_ready !== 1'b0)
      $display("FAIL backpressure got %b want 0", b0.in_ready);
    else passed++;
    tick();
    total++;
    if (b0.out_data !== pk(32'hA0, 32'hA1, 32'hA2, 32'hA3)
        || b0.fill_cnt !== 3'd4)
      $display("FAIL stable got %h f=%0d", b0.out_data, b0.fill_cnt);
    else passed++;
    b0.in_data = 32'hA4; b0.out_ready = 1;
    #1;
    total++;
    if (b0.in_ready !== 1'b1)
      $display("FAIL consume_rdy got %b want 1", b0.in_ready);
    else passed++;
    tick();
    b0.in_valid = 0; b0.out_ready = 0;
    total++;
    if (b0.fill_cnt !== 3'd1 || b0.out_valid !== 1'b0)
      $display("FAIL consume_fill got f=%0d v=%b want 1/0",
               b0.fill_cnt, b0.out_valid);
    else passed++;
    total++;
    if (b0.out_data !== pk(32'hA1, 32'hA2, 32'hA3, 32'hA4))
      $display("FAIL consume_lanes got %h", b0.out_data);
    else passed++;
  endtask

  task automatic test_sliding();
    b1.clr = 1; tick(); b1.clr = 0;
    for (int i = 0; i < 6; i++) begin
      b1.in_valid = 1; b1.in_data = 32'(i);
      #1;
      total++;
      if (b1.in_ready !== 1'b1)
        $display("FAIL slide_rdy%0d got %b want 1", i, b1.in_ready);
      else passed++;
      tick();
      total++;
      if (b1.out_valid !== (i >= 3))
        $display("FAIL slide_valid%0d got %b want %b",
                 i, b1.out_valid, (i >= 3));
      else passed++;
    end
    b1.in_valid = 0;
    total++;
    if (b1.out_data !== pk(2, 3, 4, 5) || b1.fill_cnt !== 3'd4)
      $display("FAIL slide_lanes got %h f=%0d",
               b1.out_data, b1.fill_cnt);
    else passed++;
  endtask

  task automatic test_load();
    clr0();
    push0(1); push0(2); push0(3); push0(4);
    b0.ld_en = 4'b0101; b0.ld_data = pk(9, 9, 9, 9);
    b0.in_valid = 1; b0.in_data = 32'h77;
    #1;
    total++;
    if (b0.in_ready !== 1'b0)
      $display("FAIL load_rdy got %b want 0", b0.in_ready);
    else passed++;
    tick();
    idle();
    total++;
    if (b0.out_data !== pk(9, 2, 9, 4) || b0.fill_cnt !== 3'd4)
      $display("FAIL load_part got %h f=%0d",
               b0.out_data, b0.fill_cnt);
    else passed++;
    clr0();
    push0(32'h11);
    b0.ld_en = 4'hF; b0.ld_data = pk(5, 6, 7, 8);
    tick();
    idle();
    total++;
    if (b0.out_data !== pk(5, 6, 7, 8) || b0.fill_cnt !== 3'd4)
      $display("FAIL load_all got %h f=%0d",
               b0.out_data, b0.fill_cnt);
    else passed++;
  endtask

  task automatic test_rotate();
    b0.ld_en = 4'hF; b0.ld_data = pk(1, 2, 3, 4);
    tick();
    idle();
    b0.rot = 1;
    tick();
    total++;
    if (b0.out_data !== pk(2, 3, 4, 1) || b0.fill_cnt !== 3'd4)
      $display("FAIL rot1 got %h f=%0d", b0.out_data, b0.fill_cnt);
    else passed++;
    tick(); tick(); tick();
    total++;
    if (b0.out_data !== pk(1, 2, 3, 4))
      $display("FAIL rot4 got %h", b0.out_data);
    else passed++;
    b0.out_ready = 1;
    tick();
    idle();
    total++;
    if (b0.out_data !== pk(2, 3, 4, 1) || b0.fill_cnt !== 3'd0)
      $display("FAIL rot_consume got %h f=%0d want f=0",
               b0.out_data, b0.fill_cnt);
    else passed++;
  endtask

  task automatic test_priority();
    b0.ld_en = 4'hF; b0.ld_data = pk(1, 2, 3, 4);
    tick();
    idle();
    b0.clr = 1; b0.rot = 1; b0.ld_en = 4'hF;
    b0.ld_data = pk(7, 7, 7, 7);
    b0.in_valid = 1; b0.in_data = 32'h99;
    #1;
    total++;
    if (b0.in_ready !== 1'b0)
      $display("FAIL prio_rdy got %b want 0", b0.in_ready);
    else passed++;
    tick();
    idle();
    total++;
    if (b0.out_data !== '0 || b0.fill_cnt !== 3'd0)
      $display("FAIL prio_clr got %h f=%0d",
               b0.out_data, b0.fill_cnt);
    else passed++;
    push0(32'h21); push0(32'h22);
    total++;
    if (b0.fill_cnt !== 3'd2)
      $display("FAIL mid_fill got %0d want 2", b0.fill_cnt);
    else passed++;
    rst = 1;
    tick();
    rst = 0;
    total++;
    if (b0.out_data !== '0 || b0.fill_cnt !== 3'd0)
      $display("FAIL mid_rst got %h f=%0d",
               b0.out_data, b0.fill_cnt);
    else passed++;
    push0(32'h55);
    total++;
    if (b0.fill_cnt !== 3'd1 || b0.out_data[127:96] !== 32'h55)
      $display("FAIL post_rst got f=%0d l3=%h want 1/55",
               b0.fill_cnt, b0.out_data[127:96]);
    else passed++;
  endtask

  task automatic test_back_to_back();
    logic [2:0] exp;
    clr0();
    b0.out_ready = 1;
    for (int i = 0; i < 8; i++) begin
      b0.in_valid = 1; b0.in_data = 32'h100 + 32'(i);
      #1;
      total++;
      if (b0.in_ready !== 1'b1)
        $display("FAIL b2b_rdy%0d got %b want 1", i, b0.in_ready);
      else passed++;
      tick();
      exp = 3'((i % 4) + 1);
      total++;
      if (b0.fill_cnt !== exp)
        $display("FAIL b2b_fill%0d got %0d want %0d",
                 i, b0.fill_cnt, exp);
      else passed++;
    end
    idle();
    total++;
    if (b0.out_data !== pk(32'h104, 32'h105, 32'h106, 32'h107))
      $display("FAIL b2b_lanes got %h", b0.out_data);
    else passed++;
  endtask

  initial begin
    idle();
    tick(); tick();
    rst = 0;
    tick();
    test_reset();
    test_fill();
    test_sliding();
    test_load();
    test_rotate();
    test_priority();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
